id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the 32x64 register file in the RV64I core.
- Captures the decoded instruction, its PC and the two register-file read operands (data_out1/data_out2, indexed by instr[19:15]/instr[24:20]).
- Applies EX/MEM and MEM/WB forwarding, detects load-use hazards, generates the sign-extended immediate, and presents one registered bundle to execute under a valid/ready handshake.

Parameters:
XLEN, 64, operand/PC/immediate width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low.
flush  in  1  kill held and incoming instruction (branch/jump redirect).
in_valid  in  1  decode presents an instruction.
in_ready  out  1  stage accepts this cycle.
in_instr  in  32  instruction word.
in_pc  in  XLEN  instruction PC.
rs1_data  in  XLEN  regfile data_out1.
rs2_data  in  XLEN  regfile data_out2.
mem_valid  in  1  EX/MEM holds a valid instruction that writes rd.
mem_is_load  in  1  EX/MEM instruction is a load (data not yet available).
mem_rd  in  5  EX/MEM destination.
mem_data  in  XLEN  EX/MEM ALU result.
wb_write  in  1  MEM/WB write enable (same signal as regfile write).
wb_rd  in  5  MEM/WB destination (same as regfile writeR).
wb_data  in  XLEN  MEM/WB data (same as regfile write_data).
out_valid  out  1  bundle valid to execute.
out_ready  in  1  execute accepts.
out_instr  out  32  registered instruction.
out_pc  out  XLEN  registered PC.
out_op1  out  XLEN  resolved rs1 operand.
out_op2  out  XLEN  resolved rs2 operand.
out_imm  out  XLEN  sign-extended immediate.
out_rd  out  5  destination; 0 for S/B-type.
hazard  out  1  load-use stall active this cycle.

Behaviour:
- Reset (rst=0, async): out_valid=0. out_instr=32'h00000013 (NOP). out_pc, out_op1, out_op2, out_imm = 0. out_rd=0.
- Operand resolution, per source, priority high to low:
  - index 0 -> 0.
  - mem_valid && !mem_is_load && mem_rd==idx -> mem_data.
  - wb_write && wb_rd==idx -> wb_data. This covers the regfile same-edge write, because the regfile read returns the pre-write value.
  - otherwise regfile data.
- rs2 is used for every opcode; forwarding is harmless for I/U/J types.
- hazard = in_valid && mem_valid && mem_is_load && mem_rd!=0 && (mem_rd==in_instr[19:15] || mem_rd==in_instr[24:20]).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Capture: on in_valid && in_ready, all out_* load at the next edge and out_valid=1. Latency is 1 cycle.
- Drain: out_valid && out_ready with no capture -> out_valid=0. Data registers hold their value.
- Back-pressure: out_valid && !out_ready -> all out_* stable, in_ready=0.
- Flush: out_valid=0 next edge regardless of out_ready/in_valid. The incoming instruction is dropped. Flush wins over a simultaneous capture.
- Immediate, by opcode in_instr[6:0], sign-extended from instr[31]:
  - I-type (0000011, 0010011, 0011011, 1100111, 1110011): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Other opcodes: 0.
- out_rd = instr[11:7], except 0 for S/B-type.
- Reset asserted mid-transfer: bundle discarded, outputs return to reset values immediately.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined: no forwarding; operands come straight from rs1_data/rs2_data. hazard additionally asserts on any nonzero source matching mem_rd while mem_valid (load or not), or matching wb_rd while wb_write. Correctness then relies on stalling until the regfile holds the value.

Test Plan:
- Reset, then rst=1 -> out_valid=0, out_instr=32'h00000013, in_ready=1.
- addi x5,x0,-1 (32'hFFF00293), rs1_data=7, in_valid=1 -> next cycle out_valid=1, out_imm=64'hFFFFFFFFFFFFFFFF, out_op1=0, out_rd=5.
- add x3,x1,x2 (32'h002081B3) with mem_valid=1, mem_rd=1, mem_data=64'hA, wb_write=1, wb_rd=2, wb_data=64'hB -> out_op1=64'hA, out_op2=64'hB. With FWD_EN undefined -> hazard=1, in_ready=0.
- Same add with mem_is_load=1, mem_rd=2 -> hazard=1, in_ready=0, no capture. Clear mem_valid -> captured next edge.
- out_valid=1, out_ready=0 for 3 cycles -> out_* stable, in_ready=0. Then out_ready=1 with in_valid=1 -> the new bundle replaces the held one in the same cycle.
- flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming instruction not captured.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, load-use stall, immediate generation.
// Build with ID_EX_FWD_EN defined to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            mem_valid,
    input  logic            mem_is_load,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            hazard
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
    } id_ex_t;

    logic [6:0] opcode;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;

    assign opcode  = in_instr[6:0];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];

    logic is_i;
    logic is_s;
    logic is_b;
    logic is_u;
    logic is_j;

    assign is_i = (opcode == OP_LOAD)  || (opcode == OP_IMM)
               || (opcode == OP_IMM32) || (opcode == OP_JALR)
               || (opcode == OP_SYSTEM);
    assign is_s = (opcode == OP_STORE);
    assign is_b = (opcode == OP_BRANCH);
    assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j = (opcode == OP_JAL);

    logic [XLEN-1:0] imm;

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_i: imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            is_s: imm = {{(XLEN-12){in_instr[31]}},
                         in_instr[31:25], in_instr[11:7]};
            is_b: imm = {{(XLEN-13){in_instr[31]}}, in_instr[31],
                         in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
            is_u: imm = {{(XLEN-32){in_instr[31]}},
                         in_instr[31:12], 12'b0};
            is_j: imm = {{(XLEN-21){in_instr[31]}}, in_instr[31],
                         in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    logic [4:0] rd;
    assign rd = (is_s || is_b) ? 5'd0 : in_instr[11:7];

    // Producer matches on nonzero sources; x0 never creates a dependency.
    logic mem_hit1;
    logic mem_hit2;
    logic wb_hit1;
    logic wb_hit2;

    assign mem_hit1 = mem_valid && (mem_rd != 5'd0) && (mem_rd == rs1_idx);
    assign mem_hit2 = mem_valid && (mem_rd != 5'd0) && (mem_rd == rs2_idx);
    assign wb_hit1  = wb_write && (wb_rd != 5'd0) && (wb_rd == rs1_idx);
    assign wb_hit2  = wb_write && (wb_rd != 5'd0) && (wb_rd == rs2_idx);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

`ifdef ID_EX_FWD_EN
    always_comb begin
        if (rs1_idx == 5'd0)
            op1 = '0;
        else if (mem_hit1 && !mem_is_load)
            op1 = mem_data;
        else if (wb_hit1)
            op1 = wb_data;
        else
            op1 = rs1_data;
    end

    always_comb begin
        if (rs2_idx == 5'd0)
            op2 = '0;
        else if (mem_hit2 && !mem_is_load)
            op2 = mem_data;
        else if (wb_hit2)
            op2 = wb_data;
        else
            op2 = rs2_data;
    end

    assign hazard = in_valid && mem_is_load && (mem_hit1 || mem_hit2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_data, wb_data, mem_is_load};

    assign op1 = (rs1_idx == 5'd0) ? '0 : rs1_data;
    assign op2 = (rs2_idx == 5'd0) ? '0 : rs2_data;

    // Without bypass paths, stall until the regfile holds every pending write.
    assign hazard = in_valid
                 && (mem_hit1 || mem_hit2 || wb_hit1 || wb_hit2);
`endif

    id_ex_t q;
    logic   valid_q;
    logic   capture;

    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            q.instr  <= NOP;
            q.pc     <= '0;
            q.op1    <= '0;
            q.op2    <= '0;
            q.imm    <= '0;
            q.rd     <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (capture) begin
            valid_q  <= 1'b1;
            q.instr  <= in_instr;
            q.pc     <= in_pc;
            q.op1    <= op1;
            q.op2    <= op2;
            q.imm    <= imm;
            q.rd     <= rd;
        end else if (valid_q && out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = q.instr;
    assign out_pc    = q.pc;
    assign out_op1   = q.op1;
    assign out_op2   = q.op2;
    assign out_imm   = q.imm;
    assign out_rd    = q.rd;

endmodule
